// File: rtl/mult_div_unit_if.sv
// Pipeline-to-MDU bundle: operation launch, MTHI/MTLO writes, busy/done status, HI/LO readback.
// Latency: wires only; the unit itself takes WIDTH+1 clocks from start to done.
// Backpressure: busy holds off new launches; a start while busy is dropped, not queued. Optional MDU_DIV0_FLAG_EN adds div_zero.
interface mult_div_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic             wen_hi;
    logic             wen_lo;
    logic [WIDTH-1:0] wd;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
`ifdef MDU_DIV0_FLAG_EN
    logic             div_zero;

    modport master (output start, op, inA, inB, wen_hi, wen_lo, wd,
                    input  busy, done, hi, lo, div_zero);
    modport slave  (input  start, op, inA, inB, wen_hi, wen_lo, wd,
                    output busy, done, hi, lo, div_zero);
`else
    modport master (output start, op, inA, inB, wen_hi, wen_lo, wd,
                    input  busy, done, hi, lo);
    modport slave  (input  start, op, inA, inB, wen_hi, wen_lo, wd,
                    output busy, done, hi, lo);
`endif
endinterface

// File: rtl/mult_div_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU unit holding HI/LO; MDU_DIV0_FLAG_EN adds a div_zero flag.
// Latency: start accepted at edge E, done pulses after edge E+WIDTH+1 (33 clocks at WIDTH=32).
// Backpressure: start and MTHI/MTLO writes are only taken when idle and not in the done cycle; otherwise dropped.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic               clock,
    input logic               reset,
    mult_div_unit_if.slave    bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               sa_q, sa_d, sb_q, sb_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d, a_q, a_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
`ifdef MDU_DIV0_FLAG_EN
    logic               dz_q, dz_d;
`endif

    logic               sgn_a, sgn_b, accept;
    logic [WIDTH-1:0]   mag_a, mag_b, new_rem, quo_s, rem_s;
    logic [WIDTH:0]     mul_sum, rem_sh;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_s;
    logic               div_ge, div0;

    // Signed ops run on magnitudes; sign flags are reapplied in FIX.
    assign sgn_a = ~bus.op[0] & bus.inA[WIDTH-1];
    assign sgn_b = ~bus.op[0] & bus.inB[WIDTH-1];
    assign mag_a = sgn_a ? -bus.inA : bus.inA;
    assign mag_b = sgn_b ? -bus.inB : bus.inB;

    // The done cycle still counts as busy for launches and MT writes.
    assign accept = (state_q == IDLE) && !done_q;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend/quotient}, shifted left each step.
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge   = rem_sh >= {1'b0, mcand_q};
    assign new_rem  = div_ge ? WIDTH'(rem_sh - {1'b0, mcand_q}) : rem_sh[WIDTH-1:0];
    assign div_next = {new_rem, acc_q[WIDTH-2:0], div_ge};

    assign prod_s = (sa_q ^ sb_q) ? -acc_q : acc_q;
    assign quo_s  = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_s  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    assign div0   = (mcand_q == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        mcand_d  = mcand_q;
        a_d      = a_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_d    = acc_q;
`ifdef MDU_DIV0_FLAG_EN
        dz_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept && bus.start) begin
                    state_d  = RUN;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    is_div_d = bus.op[1];
                    sa_d     = sgn_a;
                    sb_d     = sgn_b;
                    a_d      = bus.inA;
                    mcand_d  = bus.op[1] ? mag_b : mag_a;
                    acc_d    = {{WIDTH{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
                end else if (accept) begin
                    if (bus.wen_hi) hi_d = bus.wd;
                    if (bus.wen_lo) lo_d = bus.wd;
                end
            end
            RUN: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_s;
                end else if (div0) begin
                    lo_d = '1;
                    hi_d = a_q;
                end else begin
                    lo_d = quo_s;
                    hi_d = rem_s;
                end
`ifdef MDU_DIV0_FLAG_EN
                dz_d = is_div_q & div0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            a_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_q    <= '0;
`ifdef MDU_DIV0_FLAG_EN
            dz_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            mcand_q  <= mcand_d;
            a_q      <= a_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            acc_q    <= acc_d;
`ifdef MDU_DIV0_FLAG_EN
            dz_q     <= dz_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
`ifdef MDU_DIV0_FLAG_EN
    assign bus.div_zero = dz_q;
`endif
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: arithmetic results, latency, busy window, dropped starts/MT writes, reset abort.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
// Every wait for done is bounded; an expired bound shows up as a latency mismatch.
module tb_mult_div_unit;
    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mult_div_unit_if #(.WIDTH(32)) bus();
    mult_div_unit #(.WIDTH(32)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.start  = 1'b0;
        bus.op     = 2'b00;
        bus.inA    = '0;
        bus.inB    = '0;
        bus.wen_hi = 1'b0;
        bus.wen_lo = 1'b0;
        bus.wd     = '0;
    endtask

    // Called at a falling edge; returns at the falling edge where done is seen (or the bound expires).
    task automatic wait_done(input int e0, output int e);
        e = e0;
        while (!bus.done && e < 100) begin
            @(posedge clock);
            e++;
            @(negedge clock);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cyc, output logic dz);
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = op;
        bus.inA   = a;
        bus.inB   = b;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        bus.inA   = '1;
        bus.inB   = '1;
        lat       = 0;
        busy_cyc  = bus.busy ? 1 : 0;
        while (!bus.done && lat < 100) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            if (bus.busy) busy_cyc++;
        end
`ifdef MDU_DIV0_FLAG_EN
        dz = bus.div_zero;
`else
        dz = 1'b0;
`endif
    endtask

    initial begin
        int   lat, bc, e, pulses;
        logic dz;

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        reset = 1'b0;

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, dz);
        check("multu_lat", 64'(lat), 64'd33);
        check("multu_busy_cycles", 64'(bc), 64'd33);
        check("multu_hi", 64'(bus.hi), 64'hFFFF_FFFE);
        check("multu_lo", 64'(bus.lo), 64'h0000_0001);
        @(negedge clock);
        check("done_one_cycle", 64'(bus.done), 64'd0);

        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, lat, bc, dz);
        check("mult_lat", 64'(lat), 64'd33);
        check("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(bus.lo), 64'hFFFF_FFEB);

        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, bc, dz);
        check("div_neg_lo", 64'(bus.lo), 64'hFFFF_FFFD);
        check("div_neg_hi", 64'(bus.hi), 64'hFFFF_FFFF);

        run_op(2'b11, 32'd7, 32'd2, lat, bc, dz);
        check("divu_lo", 64'(bus.lo), 64'd3);
        check("divu_hi", 64'(bus.hi), 64'd1);
`ifdef MDU_DIV0_FLAG_EN
        check("divu_dz_clear", 64'(dz), 64'd0);
`endif

        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, dz);
        check("div_ovf_lo", 64'(bus.lo), 64'h8000_0000);
        check("div_ovf_hi", 64'(bus.hi), 64'd0);

        run_op(2'b11, 32'd5, 32'd0, lat, bc, dz);
        check("div0_lat", 64'(lat), 64'd33);
        check("div0_lo", 64'(bus.lo), 64'hFFFF_FFFF);
        check("div0_hi", 64'(bus.hi), 64'd5);
`ifdef MDU_DIV0_FLAG_EN
        check("div0_flag", 64'(dz), 64'd1);
`endif

        // Second start at E+5 and MTLO at E+10 must both be dropped.
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.inA   = 32'd3;
        bus.inB   = 32'd4;
        @(posedge clock);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (k == 11) check("mtlo_busy_dropped", 64'(bus.lo), 64'hFFFF_FFFF);
            bus.start  = (k == 5);
            bus.inA    = 32'd5;
            bus.inB    = 32'd5;
            bus.wen_lo = (k == 10);
            bus.wd     = 32'h0000_AAAA;
            @(posedge clock);
        end
        @(negedge clock);
        idle_inputs();
        wait_done(12, e);
        check("ignored_start_lat", 64'(e), 64'd33);
        check("ignored_start_hi", 64'(bus.hi), 64'd0);
        check("ignored_start_lo", 64'(bus.lo), 64'd12);

        // Reset at E+10 aborts the operation.
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.inA   = 32'd3;
        bus.inB   = 32'd4;
        @(posedge clock);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            bus.start = 1'b0;
            reset     = (k == 10);
            @(posedge clock);
        end
        @(negedge clock);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_hi", 64'(bus.hi), 64'd0);
        check("abort_lo", 64'(bus.lo), 64'd0);
        reset  = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.done) pulses++;
        end
        check("abort_no_done", 64'(pulses), 64'd0);

        // MTHI/MTLO in idle.
        bus.wen_lo = 1'b1;
        bus.wd     = 32'h0000_5678;
        @(posedge clock);
        @(negedge clock);
        bus.wen_lo = 1'b0;
        check("mtlo_lo", 64'(bus.lo), 64'h5678);
        check("mtlo_hi_kept", 64'(bus.hi), 64'd0);
        bus.wen_hi = 1'b1;
        bus.wd     = 32'h0000_1234;
        @(posedge clock);
        @(negedge clock);
        bus.wen_hi = 1'b0;
        check("mthi_hi", 64'(bus.hi), 64'h1234);
        check("mthi_lo_kept", 64'(bus.lo), 64'h5678);
        bus.wen_hi = 1'b1;
        bus.wen_lo = 1'b1;
        bus.wd     = 32'd9;
        @(posedge clock);
        @(negedge clock);
        check("mt_both_hi", 64'(bus.hi), 64'd9);
        check("mt_both_lo", 64'(bus.lo), 64'd9);

        // MTHI together with an accepted start is dropped.
        bus.wen_lo = 1'b0;
        bus.wen_hi = 1'b1;
        bus.wd     = 32'h0000_DEAD;
        bus.start  = 1'b1;
        bus.op     = 2'b01;
        bus.inA    = 32'd2;
        bus.inB    = 32'd3;
        @(posedge clock);
        @(negedge clock);
        idle_inputs();
        check("start_wins_busy", 64'(bus.busy), 64'd1);
        check("start_wins_hi", 64'(bus.hi), 64'd9);
        wait_done(0, e);
        check("start_wins_lat", 64'(e), 64'd33);
        check("start_wins_res_hi", 64'(bus.hi), 64'd0);
        check("start_wins_res_lo", 64'(bus.lo), 64'd6);

        // Start during the done cycle is ignored.
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.inA   = 32'd7;
        bus.inB   = 32'd7;
        @(posedge clock);
        @(negedge clock);
        idle_inputs();
        check("start_on_done_busy", 64'(bus.busy), 64'd0);
        repeat (40) @(negedge clock);
        check("start_on_done_lo", 64'(bus.lo), 64'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
